uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. Captures each received byte when the receiver's `rx_done` rises and stores it in a parameterised circular FIFO. The consumer reads bytes through a show-ahead valid/ready interface. Occupancy and full/empty flags are reported, and bytes lost to a full buffer set a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 16: number of byte slots; power of two, at least 2.
- `AW`, log2(DEPTH): local parameter, derived; pointer width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; every flop is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_done` in 1: completion flag from the receiver. A 0→1 transition marks a new byte.
- `rx_data` in 8: received byte. Stable while `rx_done` is high.
- `rd_ready` in 1: consumer accepts the head byte this cycle.
- `rd_valid` out 1: head byte present; equals not-empty.
- `rd_data` out 8: head byte, show-ahead. Don't-care when `rd_valid` is 0.
- `count` out AW+1: occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky; set when a byte is dropped.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- Edge detect: `done_d` registers `rx_done`. `push = rx_done & ~done_d`.
  - `done_d` resets to 1, so an `rx_done` already high when reset is released produces no push.
- Pop: `pop = rd_valid & rd_ready`. Head pointer advances; `count` decrements.
- Push accepted when `!full`, or when `full & pop` in the same cycle:
  - `rx_data` is written at the write pointer, the write pointer advances, and `count` increments.
- Push refused when `full` and no pop: the byte is discarded and `overflow` is set at the next edge. Pointers and `count` are unchanged.
- Push and pop in the same cycle, not full: both occur and `count` is unchanged.
- Push while empty: no pop is possible that cycle (`rd_valid` is 0).
- Pointers are AW bits wide and wrap from DEPTH-1 to 0. `count` is held in its own AW+1-bit register.
- `overflow`: a set from a dropped byte beats `ovf_clr` in the same cycle. Otherwise `ovf_clr` forces it to 0.
- `rd_ready` while empty is ignored.
- `rd_data` is driven combinationally from `mem[rd_ptr]`.

## Timing
- Reset (asynchronous, while `reset` is 0):
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `rd_valid` = 0, `overflow` = 0, `done_d` = 1.
  - Memory contents are not reset.
- Reset asserted mid-operation: all buffered bytes are discarded immediately. The outputs above take their reset values without waiting for a clock edge.
- Write latency: push sampled at edge N → `rd_valid` = 1 and `rd_data` = byte after edge N, visible in cycle N+1.
- Pop: handshake sampled at edge N → next byte, or `rd_valid` = 0, after edge N.
- `full`, `empty` and `count` are registered or decoded from registered state; they update at the same edge as the push or pop.
- At most one push per `rx_done` rising edge. A level held high for many cycles pushes exactly once.
- `rx_done` has no minimum low time; one low cycle re-arms the edge detector.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W = 8` and the byte typedef, shared with the receiver and transmitter.
- One sub-module, `uart_fifo_ram`: DEPTH×8 storage array with one synchronous write port and one asynchronous read port.
- The top level holds the edge detector, pointers, count, flags and overflow logic.

## Test plan
1. Reset and idle: `reset` low with `rx_done` high, then release. Required: `empty` = 1, `count` = 0, `rd_valid` = 0, and no push while `rx_done` stays high.
2. Single byte: `rx_done` rises with `rx_data` = 8'hA5 and stays high for 10 cycles. Required: exactly one push; `count` = 1 and `rd_data` = A5 the next cycle. Pulse `rd_ready` once → `empty` = 1.
3. Order and wrap: with DEPTH = 16, push 0x00..0x13 while popping, keeping occupancy at or below 8. Required: bytes are read back in order and pointers wrap with no loss.
4. Overflow: push 17 bytes with no pop. Required: `full` = 1 after the 16th push; the 17th is dropped; `overflow` = 1; the head is still byte 1. Assert `ovf_clr` → `overflow` = 0.
5. Full with simultaneous push and pop: when full, push 8'h3C in the same cycle `rd_ready` = 1. Required: push accepted, `count` stays 16, no overflow, and 3C is read last.
6. Reset mid-stream: 5 bytes buffered, then pulse `reset` low between clock edges. Required: `count` = 0 and `rd_valid` = 0 immediately, `overflow` = 0, and the next push reads back correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and receive buffer.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer bundle of the UART receive buffer.
// Read side is show-ahead: rd_data is the head whenever rd_valid is 1, and the
// byte is consumed on any rising clock edge where rd_valid and rd_ready are both 1.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic       rx_done;
  uart_byte_t rx_data;
  logic       rd_ready;
  logic       rd_valid;
  uart_byte_t rd_data;
  logic [AW:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  modport slave (
    input  rx_done, rx_data, rd_ready, ovf_clr,
    output rd_valid, rd_data, count, full, empty, overflow
  );

  modport master (
    output rx_done, rx_data, rd_ready, ovf_clr,
    input  rd_valid, rd_data, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);
  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: captures a byte on each rx_done rising edge into a circular
// FIFO and presents it to the consumer with a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full, empty, push, pop, accept, drop;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign push   = bus.rx_done & ~done_q;
  assign pop    = ~empty & bus.rd_ready;
  // A pop frees the slot in the same cycle, so a full buffer can still accept.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    done_d     = bus.rx_done;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  // done_q resets high so a level already present at reset release is not a byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_q),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = ~empty;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard and sticky-flag model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic       m_ovf;
  int         pass_cnt;
  int         total_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_level(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    check({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(bus.full),  32'(exp_q.size() == DEPTH));
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'(exp_q.size() != 0));
  endtask

  // One rx_done pulse (one high cycle, one low cycle), optionally popping and clearing.
  task automatic send_byte(input logic [7:0] b, input logic do_pop, input logic clr);
    logic popped;
    logic accepted;
    popped   = do_pop && (exp_q.size() > 0);
    accepted = (exp_q.size() < DEPTH) || popped;
    bus.rx_data  = b;
    bus.rx_done  = 1'b1;
    bus.rd_ready = do_pop;
    bus.ovf_clr  = clr;
    if (popped) check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    if (!accepted) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    step();
    if (accepted) exp_q.push_back(b);
    bus.rx_done  = 1'b0;
    bus.rd_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    check("ovf", 32'(bus.overflow), 32'(m_ovf));
    step();
  endtask

  task automatic pop_byte();
    check("pop_valid", 32'(bus.rd_valid), 32'd1);
    if (exp_q.size() > 0) check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    m_ovf     = 1'b0;
    reset        = 1'b0;
    bus.rx_done  = 1'b1;
    bus.rx_data  = 8'h5A;
    bus.rd_ready = 1'b0;
    bus.ovf_clr  = 1'b0;

    // 1: reset with rx_done already high; no push after release.
    repeat (3) @(negedge clk);
    check_level("rst");
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b1;
    repeat (5) step();
    check_level("idle_high");
    bus.rx_done = 1'b0;
    step();

    // 2: one long rx_done level gives exactly one push.
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    step();
    exp_q.push_back(8'hA5);
    check_level("single");
    check("single_data", 32'(bus.rd_data), 32'h0A5);
    repeat (9) step();
    check_level("single_hold");
    bus.rx_done = 1'b0;
    step();
    pop_byte();
    check_level("single_popped");
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    check_level("pop_empty_ignored");

    // 3: ordering through pointer wrap, occupancy kept at or below 8.
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i), (exp_q.size() >= 8) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
      check("wrap_count", 32'(bus.count), 32'(exp_q.size()));
    end
    while (exp_q.size() > 0) pop_byte();
    check_level("wrap_drained");

    // 4: overflow on the 17th byte, clear, and set-beats-clear.
    for (int i = 1; i <= 17; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
      if (i == 16) check("full_at_16", 32'(bus.full), 32'd1);
    end
    check_level("ovf_full");
    check("ovf_head", 32'(bus.rd_data), 32'(exp_q[0]));
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check("ovf_cleared", 32'(bus.overflow), 32'(m_ovf));
    send_byte(8'hEE, 1'b0, 1'b1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check("ovf_cleared2", 32'(bus.overflow), 32'(m_ovf));

    // 5: full with simultaneous push and pop.
    send_byte(8'h3C, 1'b1, 1'b0);
    check_level("full_pp");
    check("full_pp_last", 32'(exp_q[DEPTH-1]), 32'h03C);
    while (exp_q.size() > 0) pop_byte();
    check_level("full_pp_drained");

    // 6: asynchronous reset between clock edges discards buffered bytes.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check_level("pre_reset");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    check("async_count", 32'(bus.count), 32'd0);
    check("async_valid", 32'(bus.rd_valid), 32'd0);
    check("async_ovf", 32'(bus.overflow), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    step();
    send_byte(8'h77, 1'b0, 1'b0);
    check_level("post_reset");
    pop_byte();
    check_level("post_reset_empty");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
